fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_queue.sv | 43 ++++
 rtl/fetch_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: word width, default reset PC, FSM encoding and prefetch entry type for the fetch unit
package fetch_pkg;
    localparam int WORD_SIZE = 16;
    localparam logic [WORD_SIZE-1:0] DEFAULT_RESET_PC = 16'h0000;
    typedef enum logic [1:0] {RUN, DISCARD, HALTED} fetch_state_e;
    typedef struct packed {
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry prefetch FIFO of {pc, inst} with push/pop/flush and occupancy count
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         Clk,
    input  logic         Reset_N,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic [AW:0]  count,
    output logic         head_valid,
    output fetch_entry_t head
);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge Clk)
        if (push) mem[wr_ptr] <= push_entry;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign head_valid = count != '0;
    // Head reads as zero when empty so the outputs are clean after reset or flush
    assign head = head_valid ? mem[rd_ptr] : '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction prefetcher with redirect/discard/halt;
// define FETCH_STATS_EN to add the num_fetched / num_discarded counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [WORD_SIZE-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int QDEPTH = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    output logic                 readM1,
    output logic [WORD_SIZE-1:0] address1,
    input  logic [WORD_SIZE-1:0] data1,
    input  logic                 mem_ready,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 stall,
    input  logic                 halt,
    output logic                 inst_valid,
    output logic [WORD_SIZE-1:0] inst,
    output logic [WORD_SIZE-1:0] inst_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [WORD_SIZE-1:0] num_fetched,
    output logic [WORD_SIZE-1:0] num_discarded
`endif
);
    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(QDEPTH);

    fetch_state_e state, state_next;
    fetch_entry_t head;
    logic [WORD_SIZE-1:0] fetch_pc, base_pc;
    logic [AW:0] cnt, cnt_next;
    logic resp, busy, drop, push, pop, issue;

    always_ff @(posedge Clk or negedge Reset_N)
        if (!Reset_N) state <= RUN;
        else state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            RUN:     state_next = (redirect & busy) ? DISCARD : (halt & ~busy) ? HALTED : RUN;
            DISCARD: state_next = mem_ready ? (halt ? HALTED : RUN) : DISCARD;
            HALTED:  state_next = halt ? HALTED : RUN;
            default: state_next = RUN;
        endcase
    end

    // Occupancy seen after this edge decides whether a new read fits, so push never overflows
    always_comb begin
        resp     = readM1 & mem_ready;
        busy     = readM1 & ~mem_ready;
        drop     = resp & (redirect | (state == DISCARD));
        push     = resp & ~drop;
        pop      = inst_valid & ~stall & ~redirect;
        cnt_next = redirect ? '0 : cnt + (AW+1)'(push) - (AW+1)'(pop);
        issue    = ~busy & ~halt & (cnt_next < FULL);
        base_pc  = redirect ? redirect_pc : fetch_pc;
    end

    // fetch_pc always holds the address of the next read to be issued
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            readM1   <= 1'b0;
            address1 <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else begin
            readM1 <= busy | issue;
            if (issue) begin
                address1 <= base_pc;
                fetch_pc <= base_pc + 16'd1;
            end else begin
                fetch_pc <= base_pc;
            end
        end
    end

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .Clk        (Clk),
        .Reset_N    (Reset_N),
        .push       (push),
        .pop        (pop),
        .flush      (redirect),
        .push_entry ({address1, data1}),
        .count      (cnt),
        .head_valid (inst_valid),
        .head       (head)
    );

    assign inst    = head.inst;
    assign inst_pc = head.pc;

`ifdef FETCH_STATS_EN
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            num_fetched   <= '0;
            num_discarded <= '0;
        end else begin
            num_fetched   <= num_fetched + 16'(pop);
            num_discarded <= num_discarded + 16'(drop);
        end
    end
`endif
endmodule
